// File: rtl/pot_pkg.sv
// Shared types and widths for the slide-potentiometer scan controller.
package pot_pkg;

    localparam int RES_W = 12;  // A2D result width
    localparam int CH_W  = 3;   // channel index width

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        GUARD,
        CONV,
        UPDATE
    } scan_state_t;

endpackage

// File: rtl/pot_iir.sv
// Combinational first-order low-pass step: filt = old + (smp - old) >>> AVG_SHIFT.
// The first sample of a channel loads straight through.
module pot_iir
    import pot_pkg::*;
#(
    parameter int AVG_SHIFT = 2
) (
    input  logic [RES_W-1:0] old_i,
    input  logic [RES_W-1:0] smp_i,
    input  logic             first_i,
    output logic [RES_W-1:0] filt_o
);

    // One filter step on a 13-bit signed difference; the sum always lies
    // between old and smp, so truncating back to RES_W bits is exact.
    function automatic logic [RES_W-1:0] filt_step(input logic [RES_W-1:0] old_v,
                                                   input logic [RES_W-1:0] smp_v);
        logic signed [RES_W:0] diff;
        logic signed [RES_W:0] step;
        logic signed [RES_W:0] sum;
        diff = $signed({1'b0, smp_v}) - $signed({1'b0, old_v});
        step = diff >>> AVG_SHIFT;
        sum  = $signed({1'b0, old_v}) + step;
        return sum[RES_W-1:0];
    endfunction

    // Select pass-through for a first sample or an unfiltered configuration.
    always_comb begin
        if (first_i || (AVG_SHIFT == 0)) begin
            filt_o = smp_i;
        end else begin
            filt_o = filt_step(old_i, smp_i);
        end
    end

endmodule

// File: rtl/pot_scan_ctrl.sv
// Round-robin A2D scan controller with a per-channel low-pass filtered
// register bank and registered readback.
module pot_scan_ctrl
    import pot_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int SCAN_DIV  = 1024,
    parameter int AVG_SHIFT = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [RES_W-1:0] rd_val,
    output logic             rd_vld,
    output logic             scan_done,
    output logic             to_err
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);

    scan_state_t        state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               ovr_q, ovr_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               skip_q, skip_d;
    logic               strt_q, scan_done_q, to_err_q;
    logic               to_set, wr_en, last_done, tick, start0;

    logic [RES_W-1:0]   bank_q [NUM_CH];
    logic [NUM_CH-1:0]  vld_q;
    logic [RES_W-1:0]   rd_val_q;
    logic               rd_vld_q;
    logic [RES_W-1:0]   old_val, filt, rd_mux_val;
    logic               first_smp, rd_mux_vld;

    assign tick = (div_q == DIV_LAST);

    // Next-state logic for the scan sequencer.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        to_cnt_d  = to_cnt_q;
        skip_d    = skip_q;
        to_set    = 1'b0;
        wr_en     = 1'b0;
        last_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = START;
            end
            WAIT_TICK: begin
                if (!en)       state_d = IDLE;
                else if (tick) state_d = START;
            end
            START: begin
                to_cnt_d = '0;
                skip_d   = 1'b0;
                state_d  = GUARD;
            end
            GUARD: begin
                // cnv_cmplt is still the previous conversion's level here
                to_cnt_d = to_cnt_q + TO_W'(1);
                state_d  = CONV;
            end
            CONV: begin
                if (cnv_cmplt) begin
                    state_d = UPDATE;
                end else if (to_cnt_q >= TO_LIM) begin
                    to_set  = 1'b1;
                    skip_d  = 1'b1;
                    state_d = UPDATE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            UPDATE: begin
                wr_en = !skip_q;
                if (ch_q == LAST_CH) begin
                    last_done = 1'b1;
                    ch_d      = '0;
                    if (!en)                state_d = IDLE;
                    else if (ovr_q || tick) state_d = START;
                    else                    state_d = WAIT_TICK;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = en ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan interval counter; restarts at every channel-0 start and flags
    // scans that outlast one interval so the next one starts without waiting.
    always_comb begin
        start0 = (state_d == START) && (ch_d == '0);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        ovr_d  = ovr_q;
        if (start0) begin
            div_d = '0;
            ovr_d = 1'b0;
        end else if (tick && (state_q != WAIT_TICK)) begin
            ovr_d = 1'b1;
        end
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            div_q       <= '0;
            ovr_q       <= 1'b0;
            to_cnt_q    <= '0;
            skip_q      <= 1'b0;
            strt_q      <= 1'b0;
            scan_done_q <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            div_q       <= div_d;
            ovr_q       <= ovr_d;
            to_cnt_q    <= to_cnt_d;
            skip_q      <= skip_d;
            strt_q      <= (state_d == START);
            scan_done_q <= last_done;
            if (to_set) to_err_q <= 1'b1;
        end
    end

    // Current channel's stored value and first-sample flag, and readback mux.
    always_comb begin
        old_val    = '0;
        first_smp  = 1'b1;
        rd_mux_val = '0;
        rd_mux_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                old_val   = bank_q[i];
                first_smp = !vld_q[i];
            end
            if (rd_ch == CH_W'(i)) begin
                rd_mux_val = bank_q[i];
                rd_mux_vld = vld_q[i];
            end
        end
    end

    pot_iir #(
        .AVG_SHIFT(AVG_SHIFT)
    ) u_iir (
        .old_i  (old_val),
        .smp_i  (res),
        .first_i(first_smp),
        .filt_o (filt)
    );

    // Filtered value bank and registered readback (a same-cycle write is not visible).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
            vld_q    <= '0;
            rd_val_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == CH_W'(i)) begin
                        bank_q[i] <= filt;
                        vld_q[i]  <= 1'b1;
                    end
                end
            end
            rd_val_q <= rd_mux_val;
            rd_vld_q <= rd_mux_vld;
        end
    end

    assign strt_cnv  = strt_q;
    assign chnnl     = ch_q;
    assign scan_done = scan_done_q;
    assign to_err    = to_err_q;
    assign rd_val    = rd_val_q;
    assign rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Self-checking bench for pot_scan_ctrl: an 8-channel instance driven by a
// randomized A2D model with a sample-level filter reference, and a 4-channel
// unfiltered instance for out-of-range readback.
`timescale 1ns/1ps
module tb_pot_scan_ctrl;

    localparam int NCH = 8, SDIV = 128, SHIFT = 2, TOUT = 4095;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-channel instance
    logic        rst, en, strt_cnv, cnv_cmplt, rd_vld, scan_done, to_err;
    logic [2:0]  chnnl, rd_ch;
    logic [11:0] res, rd_val;

    // 4-channel instance
    logic        en_b, strt_b, cmp_b, rd_vld_b, sd_b, to_err_b;
    logic [2:0]  chnnl_b, rd_ch_b;
    logic [11:0] res_b, rd_val_b;

    pot_scan_ctrl #(.NUM_CH(NCH), .SCAN_DIV(SDIV), .AVG_SHIFT(SHIFT), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .rd_ch(rd_ch), .rd_val(rd_val),
        .rd_vld(rd_vld), .scan_done(scan_done), .to_err(to_err));

    pot_scan_ctrl #(.NUM_CH(4), .SCAN_DIV(64), .AVG_SHIFT(0), .TIMEOUT(100)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .strt_cnv(strt_b), .chnnl(chnnl_b),
        .cnv_cmplt(cmp_b), .res(res_b), .rd_ch(rd_ch_b), .rd_val(rd_val_b),
        .rd_vld(rd_vld_b), .scan_done(sd_b), .to_err(to_err_b));

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] val;
        logic        vld;
    } rd_vec_t;

    rd_vec_t tab_a[8];
    rd_vec_t tab_b[8];

    int n_checks = 0, n_err = 0;
    int cyc = 0, nsd = 0, t_never = 0;
    int chseq[$];
    int t0q[$];
    int lat_min = 2, lat_max = 8;
    bit stale_mode = 1'b0, never_en = 1'b0;
    logic [2:0]  never_ch = 3'd5;
    logic [11:0] val[8];
    logic [11:0] val_b[4];
    int exp_val[8];
    bit exp_vld[8];
    int exp3[3];

    // Reference filter: floor((res - filt) / 2^SHIFT) added to filt.
    function automatic int ref_filt(input int old, input int smp, input bit first);
        int d, q;
        if (first || SHIFT == 0) return smp;
        d = smp - old;
        q = 1 << SHIFT;
        if (d >= 0) d = d / q;
        else        d = -((-d + q - 1) / q);
        return (old + d) % 4096;
    endfunction

    // A2D model for the 8-channel instance plus the expected-bank reference.
    int         a_lat;
    bit         a_busy, a_stale;
    logic [2:0] a_ch;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (scan_done) nsd <= nsd + 1;
        if (rst) begin
            cnv_cmplt <= 1'b0;
            res       <= '0;
            a_busy    <= 1'b0;
            a_stale   <= 1'b0;
            a_lat     <= 0;
            for (int i = 0; i < 8; i++) begin
                exp_val[i] <= 0;
                exp_vld[i] <= 1'b0;
            end
        end else begin
            if (a_stale) begin
                cnv_cmplt <= 1'b0;
                a_stale   <= 1'b0;
            end
            if (strt_cnv) begin
                chseq.push_back(int'(chnnl));
                if (chnnl == 3'd0) t0q.push_back(cyc);
                if (never_en && chnnl == never_ch) t_never <= cyc;
                a_ch   <= chnnl;
                a_busy <= 1'b1;
                a_lat  <= int'($urandom_range(lat_max, lat_min));
                if (stale_mode) a_stale <= 1'b1;
                else            cnv_cmplt <= 1'b0;
            end else if (a_busy) begin
                if (a_lat == 0) begin
                    a_busy <= 1'b0;
                    if (!(never_en && a_ch == never_ch)) begin
                        cnv_cmplt      <= 1'b1;
                        res            <= val[a_ch];
                        exp_val[a_ch]  <= ref_filt(exp_val[a_ch], int'(val[a_ch]), !exp_vld[a_ch]);
                        exp_vld[a_ch]  <= 1'b1;
                    end
                end else begin
                    a_lat <= a_lat - 1;
                end
            end
        end
    end

    // Fixed-latency A2D model for the 4-channel instance.
    bit         b_busy;
    int         b_lat;
    logic [2:0] b_ch;
    int         nsd_b = 0;
    always @(posedge clk) begin
        if (sd_b) nsd_b <= nsd_b + 1;
        if (rst) begin
            cmp_b  <= 1'b0;
            res_b  <= '0;
            b_busy <= 1'b0;
            b_lat  <= 0;
        end else if (strt_b) begin
            cmp_b  <= 1'b0;
            b_ch   <= chnnl_b;
            b_busy <= 1'b1;
            b_lat  <= 3;
        end else if (b_busy) begin
            if (b_lat == 0) begin
                cmp_b  <= 1'b1;
                res_b  <= val_b[b_ch[1:0]];
                b_busy <= 1'b0;
            end else begin
                b_lat <= b_lat - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic rd(input logic [2:0] c, output logic [11:0] v, output logic vl);
        @(negedge clk) rd_ch = c;
        @(posedge clk); #1;
        v  = rd_val;
        vl = rd_vld;
    endtask

    task automatic rd_b(input logic [2:0] c, output logic [11:0] v, output logic vl);
        @(negedge clk) rd_ch_b = c;
        @(posedge clk); #1;
        v  = rd_val_b;
        vl = rd_vld_b;
    endtask

    task automatic check_all(input string tag);
        logic [11:0] v;
        logic        vl;
        for (int c = 0; c < 8; c++) begin
            rd(3'(c), v, vl);
            chk($sformatf("%s_val_ch%0d", tag, c), 32'(v), 32'(exp_val[c]));
            chk($sformatf("%s_vld_ch%0d", tag, c), 32'(vl), 32'(exp_vld[c]));
        end
    endtask

    task automatic wait_done(input int n);
        int start, k;
        start = nsd;
        k = 0;
        while (nsd < start + n && k < 20000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("scan_done_wait", 32'(nsd >= start + n), 32'd1);
    endtask

    task automatic wait_strt(input int ch, input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk); #1;
            if (strt_cnv && (ch < 0 || int'(chnnl) == ch)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_scan();
        en = 1'b1;
        wait_done(1);
        en = 1'b0;
        idle(30);
    endtask

    task automatic randomize_vals();
        for (int c = 0; c < 8; c++) val[c] = 12'($urandom);
    endtask

    initial begin
        logic [11:0] v;
        logic        vl;
        bit          ok;
        int          lat, start;

        for (int c = 0; c < 8; c++) begin
            tab_a[c] = '{ch: 3'(c), val: 12'h800, vld: 1'b1};
            tab_b[c] = '{ch: 3'(c), val: (c < 4) ? 12'(12'h5A0 + c) : 12'h000, vld: (c < 4)};
        end
        exp3[0] = 12'h100; exp3[1] = 12'h1C0; exp3[2] = 12'h250;

        rst = 1'b1; en = 1'b0; en_b = 1'b0; rd_ch = '0; rd_ch_b = '0;
        for (int c = 0; c < 8; c++) val[c] = 12'h800;
        for (int c = 0; c < 4; c++) val_b[c] = 12'(12'h111 * (c + 1));
        idle(3);
        rst = 1'b0;

        // Reset state
        chk("rst_strt_cnv", 32'(strt_cnv), 0);
        chk("rst_chnnl", 32'(chnnl), 0);
        chk("rst_rd_val", 32'(rd_val), 0);
        chk("rst_rd_vld", 32'(rd_vld), 0);
        chk("rst_scan_done", 32'(scan_done), 0);
        chk("rst_to_err", 32'(to_err), 0);

        // 4-channel, unfiltered: latest sample only; rd_ch beyond NUM_CH reads 0/0
        en_b = 1'b1;
        start = nsd_b;
        for (int k = 0; k < 2000 && nsd_b < start + 1; k++) begin @(posedge clk); #1; end
        for (int c = 0; c < 4; c++) val_b[c] = 12'(12'h5A0 + c);
        for (int k = 0; k < 2000 && nsd_b < start + 2; k++) begin @(posedge clk); #1; end
        en_b = 1'b0;
        chk("b_two_scans", 32'(nsd_b - start), 2);
        idle(30);
        for (int i = 0; i < 8; i++) begin
            rd_b(tab_b[i].ch, v, vl);
            chk($sformatf("b_rd_val_ch%0d", tab_b[i].ch), 32'(v), 32'(tab_b[i].val));
            chk($sformatf("b_rd_vld_ch%0d", tab_b[i].ch), 32'(vl), 32'(tab_b[i].vld));
        end

        // First scan at 0x800: en to strt_cnv is one cycle, channels 0..7, one scan_done
        @(posedge clk); #1;
        chseq.delete();
        start = nsd;
        en = 1'b1;
        @(posedge clk); #1;
        chk("en_to_strt", 32'(strt_cnv), 1);
        chk("first_chnnl", 32'(chnnl), 0);
        wait_done(1);
        en = 1'b0;
        idle(30);
        chk("scan_done_once", 32'(nsd - start), 1);
        chk("chseq_len", 32'(chseq.size()), 8);
        for (int i = 0; i < 8 && i < chseq.size(); i++)
            chk($sformatf("chseq_%0d", i), 32'(chseq[i]), 32'(i));
        for (int i = 0; i < 8; i++) begin
            rd(tab_a[i].ch, v, vl);
            chk($sformatf("scan1_val_ch%0d", tab_a[i].ch), 32'(v), 32'(tab_a[i].val));
            chk($sformatf("scan1_vld_ch%0d", tab_a[i].ch), 32'(vl), 32'(tab_a[i].vld));
        end
        chk("scan1_to_err", 32'(to_err), 0);

        // Filter steps on channel 3: 0x000 then 0x400 -> 0x100, 0x1C0, 0x250
        pulse_rst();
        randomize_vals();
        val[3] = 12'h000;
        run_scan();
        rd(3'd3, v, vl);
        chk("ch3_zero", 32'(v), 0);
        val[3] = 12'h400;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 8; c++) if (c != 3) val[c] = 12'($urandom);
            run_scan();
            rd(3'd3, v, vl);
            chk($sformatf("ch3_step%0d", k), 32'(v), 32'(exp3[k]));
            check_all($sformatf("filt%0d", k));
        end

        // Stale-high completion during GUARD; two back-to-back scans one interval apart
        stale_mode = 1'b1;
        randomize_vals();
        t0q.delete();
        en = 1'b1;
        wait_done(1);
        randomize_vals();
        wait_done(1);
        en = 1'b0;
        idle(30);
        stale_mode = 1'b0;
        check_all("stale");
        chk("interval_starts", 32'(t0q.size() >= 2), 1);
        if (t0q.size() >= 2) chk("scan_interval", 32'(t0q[1] - t0q[0]), 32'(SDIV));

        // Channel 5 never completes: timeout, skip write, move on to 6; long scan restarts at once
        chk("pre_to_err", 32'(to_err), 0);
        randomize_vals();
        never_en = 1'b1;
        chseq.delete();
        en = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 9000; k++) begin
            @(posedge clk); #1;
            if (to_err) begin ok = 1'b1; break; end
        end
        chk("to_err_set", 32'(ok), 1);
        lat = cyc - t_never;
        chk("to_latency_in_range", 32'(lat >= TOUT - 2 && lat <= TOUT + 4), 1);
        wait_strt(-1, 50, ok);
        chk("after_to_strt", 32'(ok), 1);
        chk("after_to_chnnl", 32'(chnnl), 6);
        wait_done(1);
        for (int k = 0; k < 3 && chseq.size() < 9; k++) begin @(posedge clk); #1; end
        chk("overrun_restart", 32'(chseq.size() >= 9), 1);
        never_en = 1'b0;
        en = 1'b0;
        idle(40);
        for (int i = 0; i < 8 && i < chseq.size(); i++)
            chk($sformatf("to_chseq_%0d", i), 32'(chseq[i]), 32'(i));
        check_all("timeout");
        chk("to_err_sticky", 32'(to_err), 1);

        // en dropped during channel 2's conversion, then resume at channel 3
        pulse_rst();
        chk("rst_clears_to_err", 32'(to_err), 0);
        randomize_vals();
        val[2] = 12'hABC;
        chseq.delete();
        en = 1'b1;
        wait_strt(2, 300, ok);
        chk("reach_ch2", 32'(ok), 1);
        idle(2);
        en = 1'b0;
        idle(40);
        chk("stop_chseq_len", 32'(chseq.size()), 3);
        rd(3'd2, v, vl);
        chk("ch2_written", 32'(v), 32'h0ABC);
        chk("ch2_vld", 32'(vl), 1);
        rd(3'd3, v, vl);
        chk("ch3_not_written", 32'(vl), 0);
        lat_min = 6;
        en = 1'b1;
        wait_strt(-1, 20, ok);
        chk("resume_strt", 32'(ok), 1);
        chk("resume_chnnl", 32'(chnnl), 3);

        // rst during CONV: all outputs at reset values one cycle later, bank cleared
        rd_ch = 3'd2;
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_strt_cnv", 32'(strt_cnv), 0);
        chk("mid_rst_chnnl", 32'(chnnl), 0);
        chk("mid_rst_rd_val", 32'(rd_val), 0);
        chk("mid_rst_rd_vld", 32'(rd_vld), 0);
        chk("mid_rst_scan_done", 32'(scan_done), 0);
        chk("mid_rst_to_err", 32'(to_err), 0);
        rst = 1'b0;
        en = 1'b0;
        check_all("post_rst");
        en = 1'b1;
        wait_strt(-1, 20, ok);
        chk("post_rst_strt", 32'(ok), 1);
        chk("post_rst_chnnl", 32'(chnnl), 0);
        en = 1'b0;
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
